// File: rtl/mac_seq_ctrl.sv
// Two-pass sequencer for an external multiply-accumulate unit: evaluates (a*x+b)*x+c
// or a*x+b*c, captures the MAC result and holds it under a valid/ready handshake.
module mac_seq_ctrl #(
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic        op,
  input  logic [7:0]  num_a,
  input  logic [7:0]  num_x,
  input  logic [7:0]  num_b,
  input  logic [7:0]  num_c,
  output logic [7:0]  in_1,
  output logic [7:0]  in_2,
  output logic [7:0]  in_add,
  output logic        mode,
  output logic        mul_input_mux,
  output logic        adder_input_mux,
  input  logic [16:0] mac_output,
  output logic [16:0] result,
  output logic        res_valid,
  input  logic        res_ready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS1 = 3'd1,
    ST_PASS2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic [7:0] in_add;
    logic       mode;
    logic       mul_mux;
    logic       add_mux;
  } drive_t;

  localparam logic [1:0] CNT_LAST = 2'(MAC_LATENCY - 1);

  state_t     state_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       cnt_last;
  logic       op_q;
  logic [7:0] a_q;
  logic [7:0] x_q;
  logic [7:0] b_q;
  logic [7:0] c_q;
  drive_t     drive_q;
  logic [16:0] result_q;
  logic        res_valid_q;
  logic        ready_q;

  // First pass: trinomial computes a*x+b, sum-of-products computes a*x.
  function automatic drive_t pass1_drive(input logic f_op, input logic [7:0] f_a,
                                         input logic [7:0] f_x, input logic [7:0] f_b);
    drive_t d;
    d.in_1    = f_a;
    d.in_2    = f_x;
    d.in_add  = f_op ? f_b : 8'd0;
    d.mode    = f_op;
    d.mul_mux = 1'b0;
    d.add_mux = 1'b0;
    return d;
  endfunction

  // Second pass reuses the first-pass result: as multiplicand (trinomial) or addend.
  function automatic drive_t pass2_drive(input logic f_op, input logic [7:0] f_a,
                                         input logic [7:0] f_x, input logic [7:0] f_b,
                                         input logic [7:0] f_c);
    drive_t d;
    d.in_1    = f_op ? f_a : f_b;
    d.in_2    = f_op ? f_x : f_c;
    d.in_add  = f_op ? f_c : 8'd0;
    d.mode    = f_op;
    d.mul_mux = f_op;
    d.add_mux = ~f_op;
    return d;
  endfunction

  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_d    = cnt_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      op_q        <= 1'b0;
      a_q         <= 8'd0;
      x_q         <= 8'd0;
      b_q         <= 8'd0;
      c_q         <= 8'd0;
      drive_q     <= '0;
      result_q    <= 17'd0;
      res_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && ready_q) begin
            op_q    <= op;
            a_q     <= num_a;
            x_q     <= num_x;
            b_q     <= num_b;
            c_q     <= num_c;
            drive_q <= pass1_drive(op, num_a, num_x, num_b);
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
            state_q <= ST_PASS1;
          end
        end
        ST_PASS1: begin
          if (cnt_last) begin
            drive_q <= pass2_drive(op_q, a_q, x_q, b_q, c_q);
            cnt_q   <= 2'd0;
            state_q <= ST_PASS2;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_PASS2: begin
          if (cnt_last) begin
            cnt_q   <= 2'd0;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WAIT: begin
          // Drive stays at PASS2 values until the MAC pipeline has flushed.
          if (cnt_last) begin
            result_q    <= mac_output;
            res_valid_q <= 1'b1;
            drive_q     <= '0;
            cnt_q       <= 2'd0;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            cnt_q       <= 2'd0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          drive_q     <= '0;
          res_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          cnt_q       <= 2'd0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready           = ready_q;
  assign in_1            = drive_q.in_1;
  assign in_2            = drive_q.in_2;
  assign in_add          = drive_q.in_add;
  assign mode            = drive_q.mode;
  assign mul_input_mux   = drive_q.mul_mux;
  assign adder_input_mux = drive_q.add_mux;
  assign result          = result_q;
  assign res_valid       = res_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC unit with configurable latency, reference
// results queued at acceptance and compared when res_valid rises.
module tb_mac_seq_ctrl;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic        op;
  logic [7:0]  num_a, num_x, num_b, num_c;
  logic [7:0]  in_1, in_2, in_add;
  logic        mode, mul_input_mux, adder_input_mux;
  logic [16:0] mac_output;
  logic [16:0] result;
  logic        res_valid;
  logic        res_ready;

  int n_chk  = 0;
  int n_pass = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.MAC_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .op(op),
    .num_a(num_a), .num_x(num_x), .num_b(num_b), .num_c(num_c),
    .in_1(in_1), .in_2(in_2), .in_add(in_add), .mode(mode),
    .mul_input_mux(mul_input_mux), .adder_input_mux(adder_input_mux),
    .mac_output(mac_output), .result(result), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  // MAC unit: out = (mux ? feedback : in_1) * in_2 + (mux ? feedback : in_add), LAT-stage pipe.
  logic [16:0] pipe [LAT];
  logic [16:0] mul_op, add_op;
  logic [31:0] mac_full;
  assign mac_output = pipe[LAT-1];
  assign mul_op   = mul_input_mux   ? mac_output : {9'd0, in_1};
  assign add_op   = adder_input_mux ? mac_output : {9'd0, in_add};
  assign mac_full = 32'(mul_op) * 32'(in_2) + 32'(add_op);

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 17'd0;
    end else begin
      pipe[0] <= mac_full[16:0];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  wire [26:0] drv = {in_1, in_2, in_add, mode, mul_input_mux, adder_input_mux};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [16:0] ref_calc(input logic f_op, input logic [7:0] a,
                                           input logic [7:0] x, input logic [7:0] b,
                                           input logic [7:0] c);
    logic [31:0] t;
    if (f_op) t = (32'(a) * 32'(x) + 32'(b)) * 32'(x) + 32'(c);
    else      t = 32'(a) * 32'(x) + 32'(b) * 32'(c);
    return t[16:0];
  endfunction

  function automatic logic [26:0] exp_drv(input logic f_op, input int phase,
                                          input logic [7:0] a, input logic [7:0] x,
                                          input logic [7:0] b, input logic [7:0] c);
    if (phase == 1) return f_op ? {a, x, b, 3'b100} : {a, x, 8'd0, 3'b000};
    return f_op ? {a, x, c, 3'b110} : {b, c, 8'd0, 3'b001};
  endfunction

  task automatic scramble();
    num_a = 8'($urandom); num_x = 8'($urandom);
    num_b = 8'($urandom); num_c = 8'($urandom);
    op    = 1'($urandom);
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_job(input logic j_op, input logic [7:0] a, input logic [7:0] x,
                         input logic [7:0] b, input logic [7:0] c,
                         input int hold, input bit poke);
    logic [16:0] exp_res;
    logic [16:0] held;
    chk("ready_before_start", 32'(ready), 32'd1);
    res_ready = (hold == 0);
    start = 1'b1; op = j_op; num_a = a; num_x = x; num_b = b; num_c = c;
    sb_q.push_back(ref_calc(j_op, a, x, b, c));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int k = 1; k <= 3*LAT+1; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        chk("pass1_drive", 32'(drv), 32'(exp_drv(j_op, 1, a, x, b, c)));
        chk("ready_busy", 32'(ready), 32'd0);
      end
      if (k == LAT+1) begin
        chk("pass2_drive", 32'(drv), 32'(exp_drv(j_op, 2, a, x, b, c)));
        if (poke) begin
          start = 1'b1;
          scramble();
        end
      end
      if (k == LAT+2) start = 1'b0;
      if (k == 2*LAT+1) chk("wait_drive", 32'(drv), 32'(exp_drv(j_op, 2, a, x, b, c)));
      if (k == 3*LAT) chk("valid_early", 32'(res_valid), 32'd0);
      if (k == 3*LAT+1) begin
        chk("valid_rise", 32'(res_valid), 32'd1);
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
          exp_res = 17'd0;
        end else begin
          exp_res = sb_q.pop_front();
        end
        chk("result", 32'(result), 32'(exp_res));
        chk("done_drive_zero", 32'(drv), 32'd0);
        chk("ready_done", 32'(ready), 32'd0);
      end
    end
    held = result;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("done_hold_valid", 32'(res_valid), 32'd1);
      chk("done_hold_result", 32'(result), 32'(held));
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("idle_valid_low", 32'(res_valid), 32'd0);
    chk("idle_ready", 32'(ready), 32'd1);
  endtask

  task automatic abort_in_wait(input logic j_op, input logic [7:0] a, input logic [7:0] x,
                               input logic [7:0] b, input logic [7:0] c);
    int saw_valid;
    res_ready = 1'b1;
    start = 1'b1; op = j_op; num_a = a; num_x = x; num_b = b; num_c = c;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 2*LAT+1; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_drive", 32'(drv), 32'd0);
    reset = 1'b0;
    saw_valid = 0;
    for (int k = 0; k < 3*LAT+2; k++) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1;
    end
    chk("abort_no_valid", 32'(saw_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; res_ready = 1'b0;
    op = 1'b0; num_a = 8'd0; num_x = 8'd0; num_b = 8'd0; num_c = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_drive", 32'(drv), 32'd0);
    // Start asserted together with reset must not be taken.
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio_ready", 32'(ready), 32'd1);
    start = 1'b0;
    reset = 1'b0;

    run_job(1'b1, 8'd5,   8'd3,   8'd2,   8'd1,   0, 1'b0);
    run_job(1'b1, 8'd9,   8'd8,   8'd7,   8'd6,   0, 1'b0);
    run_job(1'b0, 8'd5,   8'd3,   8'd9,   8'd8,   0, 1'b0);
    run_job(1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 0, 1'b0);
    run_job(1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 0, 1'b0);
    run_job(1'b1, 8'd12,  8'd34,  8'd56,  8'd78,  5, 1'b1);
    run_job(1'b0, 8'd17,  8'd4,   8'd200, 8'd3,   0, 1'b0);
    abort_in_wait(1'b1, 8'd100, 8'd99, 8'd98, 8'd97);
    run_job(1'b1, 8'd5,   8'd3,   8'd2,   8'd1,   0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_job(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
